// File: rtl/core_sequencer.sv
// Instruction sequencer for a SIMD core: fetches opcodes, steps ALU and memory
// operations through a fixed pipeline of states, and tracks per-lane memory acks.
module core_sequencer #(
    parameter int NUM_LANES = 4,
    parameter int OPCODE_W  = 4,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [NUM_LANES-1:0] lane_mask,
    input  logic                 instr_valid,
    input  logic [OPCODE_W-1:0]  opcode,
    output logic                 instr_ready,
    input  logic [NUM_LANES-1:0] mem_ack,
    output logic                 alu_enable,
    output logic [2:0]           alu_op,
    output logic                 reg_write,
    output logic                 mem_read,
    output logic                 mem_write,
    output logic                 done,
    output logic                 error,
    output logic [CNT_W-1:0]     instr_count
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, DONE
    } state_t;

    typedef enum logic [2:0] {
        CL_ALU, CL_LOAD, CL_STORE, CL_RET, CL_NOP
    } op_class_t;

    state_t                state, next_state;
    logic [OPCODE_W-1:0]   opcode_q;
    logic [NUM_LANES-1:0]  mask_q;
    logic [NUM_LANES-1:0]  acked;
    logic [WAIT_W-1:0]     wait_cnt;
    op_class_t             op_class;
    logic [2:0]            alu_code;
    logic                  mem_done;
    logic                  timed_out;

    always_comb begin
        op_class = CL_NOP;
        alu_code = 3'b000;
        case (opcode_q)
            OPCODE_W'(0): op_class = CL_ALU;
            OPCODE_W'(1): begin op_class = CL_ALU; alu_code = 3'b001; end
            OPCODE_W'(2): begin op_class = CL_ALU; alu_code = 3'b010; end
            OPCODE_W'(3): op_class = CL_LOAD;
            OPCODE_W'(4): op_class = CL_STORE;
            OPCODE_W'(5): begin op_class = CL_ALU; alu_code = 3'b011; end
            OPCODE_W'(6): begin op_class = CL_ALU; alu_code = 3'b100; end
            OPCODE_W'(7): op_class = CL_RET;
            default:      op_class = CL_NOP;
        endcase
    end

    // Acks arriving this cycle count immediately, so an all-zero mask finishes in one cycle.
    assign mem_done  = (((acked | mem_ack) & mask_q) == mask_q);
    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));

    // NOTE: every output and next_state get a default first so no path infers a latch.
    always_comb begin
        next_state  = state;
        instr_ready = 1'b0;
        alu_enable  = 1'b0;
        alu_op      = 3'b000;
        reg_write   = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE:      if (start) next_state = FETCH;
            FETCH: begin
                instr_ready = 1'b1;
                if (instr_valid) next_state = DECODE;
            end
            DECODE: begin
                case (op_class)
                    CL_ALU:            next_state = EXECUTE;
                    CL_LOAD, CL_STORE: next_state = MEM_WAIT;
                    CL_RET:            next_state = DONE;
                    default:           next_state = FETCH;
                endcase
            end
            EXECUTE: begin
                alu_enable = 1'b1;
                alu_op     = alu_code;
                next_state = WRITEBACK;
            end
            MEM_WAIT: begin
                mem_read  = (op_class == CL_LOAD);
                mem_write = (op_class == CL_STORE);
                if (mem_done)       next_state = (op_class == CL_LOAD) ? WRITEBACK : FETCH;
                else if (timed_out) next_state = DONE;
            end
            WRITEBACK: begin
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            DONE: begin
                done = 1'b1;
                if (!start) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments; all registers, including opcode_q, are reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            opcode_q    <= '0;
            mask_q      <= '0;
            acked       <= '0;
            wait_cnt    <= '0;
            instr_count <= '0;
            error       <= 1'b0;
        end else begin
            state <= next_state;
            case (state)
                IDLE: begin
                    if (start) begin
                        mask_q      <= lane_mask;
                        instr_count <= '0;
                        error       <= 1'b0;
                    end
                end
                FETCH: if (instr_valid) opcode_q <= opcode;
                DECODE: begin
                    instr_count <= instr_count + CNT_W'(1);
                    acked       <= '0;
                    wait_cnt    <= '0;
                end
                MEM_WAIT: begin
                    acked    <= acked | (mem_ack & mask_q);
                    wait_cnt <= wait_cnt + WAIT_W'(1);
                    if (!mem_done && timed_out) error <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: ALU, load/store, timeout, NOP, counter wrap
// and asynchronous reset scenarios with hand-computed expectations.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  lane_mask;
    logic        instr_valid;
    logic [3:0]  opcode;
    logic [3:0]  mem_ack;
    logic        instr_ready, alu_enable, reg_write, mem_read, mem_write, done, error;
    logic [2:0]  alu_op;
    logic [15:0] instr_count;
    logic        w_instr_ready, w_alu_enable, w_reg_write, w_mem_read, w_mem_write, w_done, w_error;
    logic [2:0]  w_alu_op;
    logic [1:0]  w_instr_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    core_sequencer #(.NUM_LANES(4), .OPCODE_W(4), .TIMEOUT(8), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .lane_mask(lane_mask),
        .instr_valid(instr_valid), .opcode(opcode), .instr_ready(instr_ready),
        .mem_ack(mem_ack), .alu_enable(alu_enable), .alu_op(alu_op),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .done(done), .error(error), .instr_count(instr_count)
    );

    core_sequencer #(.NUM_LANES(4), .OPCODE_W(4), .TIMEOUT(8), .CNT_W(2)) dut_w (
        .clk(clk), .reset(reset), .start(start), .lane_mask(lane_mask),
        .instr_valid(instr_valid), .opcode(opcode), .instr_ready(w_instr_ready),
        .mem_ack(mem_ack), .alu_enable(w_alu_enable), .alu_op(w_alu_op),
        .reg_write(w_reg_write), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .done(w_done), .error(w_error), .instr_count(w_instr_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one opcode in FETCH and move on to DECODE.
    task automatic issue(input logic [3:0] op);
        opcode      = op;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    function automatic logic [31:0] strobes();
        return 32'({alu_enable, mem_read, mem_write, reg_write});
    endfunction

    initial begin
        reset = 1'b1; start = 1'b0; lane_mask = '0;
        instr_valid = 1'b0; opcode = '0; mem_ack = '0;
        #1;
        check("rst_ready", 32'(instr_ready), 0);
        check("rst_done", 32'(done), 0);
        check("rst_error", 32'(error), 0);
        check("rst_count", 32'(instr_count), 0);
        check("rst_strobes", strobes(), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        step();
        check("idle_no_start", 32'(instr_ready), 0);

        // ADD, SUB, RET with all lanes active
        lane_mask = 4'b1111; start = 1'b1;
        step();
        check("t1_fetch_ready", 32'(instr_ready), 1);
        issue(4'd0);
        check("t1_decode_ready", 32'(instr_ready), 0);
        check("t1_decode_strobes", strobes(), 0);
        step();
        check("t1_add_alu_en", 32'(alu_enable), 1);
        check("t1_add_alu_op", 32'(alu_op), 0);
        check("t1_add_regw_low", 32'(reg_write), 0);
        check("t1_count1", 32'(instr_count), 1);
        step();
        check("t1_add_wb", strobes(), 32'b0001);
        step();
        check("t1_add_back_fetch", 32'(instr_ready), 1);
        issue(4'd1);
        step();
        check("t1_sub_alu_en", 32'(alu_enable), 1);
        check("t1_sub_alu_op", 32'(alu_op), 1);
        step();
        check("t1_sub_wb", strobes(), 32'b0001);
        step();
        issue(4'd7);
        step();
        check("t1_done", 32'(done), 1);
        check("t1_count3", 32'(instr_count), 3);
        check("t1_error", 32'(error), 0);
        check("t1_done_strobes", strobes(), 0);
        start = 1'b0;
        step();
        check("t1_idle", 32'(done), 0);

        // LOAD on lanes 0 and 2, stray acks on lanes 1 and 3
        lane_mask = 4'b0101; mem_ack = 4'b1010; start = 1'b1;
        step();
        start = 1'b0;
        check("t2_count_clear", 32'(instr_count), 0);
        issue(4'd3);
        mem_ack = 4'b0000;
        step();
        for (int c = 1; c <= 5; c++) begin
            check($sformatf("t2_mem_read_c%0d", c), strobes(), 32'b0100);
            mem_ack = (c == 1) ? 4'b1010 : (c == 2) ? 4'b0001 : (c == 5) ? 4'b0100 : 4'b0000;
            step();
        end
        mem_ack = 4'b0000;
        check("t2_load_wb", strobes(), 32'b0001);
        step();
        check("t2_back_fetch", 32'(instr_ready), 1);
        issue(4'd7);
        step();
        check("t2_count2", 32'(instr_count), 2);
        step();

        // STORE with no acks times out after 8 cycles
        lane_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        issue(4'd4);
        step();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t3_mem_write_c%0d", c), strobes(), 32'b0010);
            step();
        end
        check("t3_timeout_error", 32'(error), 1);
        check("t3_timeout_done", 32'(done), 1);
        check("t3_timeout_strobes", strobes(), 0);
        step();
        check("t3_idle_error_held", 32'(error), 1);
        check("t3_idle_done_low", 32'(done), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t3_restart_error_clear", 32'(error), 0);

        // STORE completing exactly on the final allowed cycle
        issue(4'd4);
        step();
        for (int c = 1; c <= 8; c++) begin
            check($sformatf("t3b_mem_write_c%0d", c), strobes(), 32'b0010);
            mem_ack = (c == 3) ? 4'b0011 : (c == 8) ? 4'b1100 : 4'b0000;
            step();
        end
        mem_ack = 4'b0000;
        check("t3b_store_fetch", 32'(instr_ready), 1);
        check("t3b_no_error", 32'(error), 0);
        check("t3b_not_done", 32'(done), 0);
        issue(4'd7);
        step();
        check("t3b_count2", 32'(instr_count), 2);
        step();

        // Empty mask LOAD and an undefined opcode
        lane_mask = 4'b0000; start = 1'b1;
        step();
        start = 1'b0;
        issue(4'd3);
        step();
        check("t4_mask0_read", strobes(), 32'b0100);
        step();
        check("t4_mask0_wb", strobes(), 32'b0001);
        step();
        issue(4'hF);
        check("t4_nop_decode_strobes", strobes(), 0);
        step();
        check("t4_nop_fetch", 32'(instr_ready), 1);
        check("t4_nop_strobes", strobes(), 0);
        check("t4_nop_count", 32'(instr_count), 2);
        issue(4'd7);
        step();
        check("t4_count3", 32'(instr_count), 3);
        step();

        // Five NOPs then RET: the 2-bit counter wraps
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            issue(4'hF);
            step();
            check($sformatf("t5_wrap_nop%0d", i), 32'(w_instr_count), (i + 1) % 4);
        end
        issue(4'd7);
        step();
        check("t5_done", 32'(done), 1);
        check("t5_count_wide", 32'(instr_count), 6);
        check("t5_count_wrapped", 32'(w_instr_count), 2);
        step();

        // Asynchronous reset in the middle of MEM_WAIT
        lane_mask = 4'b1111; start = 1'b1;
        step();
        start = 1'b0;
        issue(4'd3);
        step();
        check("t6_pre_reset_read", 32'(mem_read), 1);
        check("t6_pre_reset_count", 32'(instr_count), 1);
        #2 reset = 1'b1;
        #1;
        check("t6_async_read_drop", 32'(mem_read), 0);
        check("t6_async_count", 32'(instr_count), 0);
        check("t6_async_ready", 32'(instr_ready), 0);
        step();
        check("t6_held_idle", strobes(), 0);
        reset = 1'b0;
        step();
        check("t6_idle_after_reset", 32'(instr_ready), 0);
        start = 1'b1;
        step();
        start = 1'b0;
        check("t6_restart_fetch", 32'(instr_ready), 1);
        issue(4'd0);
        step();
        check("t6_restart_alu", 32'(alu_enable), 1);
        step();
        check("t6_restart_wb", strobes(), 32'b0001);
        step();
        issue(4'd7);
        step();
        check("t6_restart_done", 32'(done), 1);
        check("t6_restart_count", 32'(instr_count), 2);
        check("t6_restart_error", 32'(error), 0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/core_sequencer.md
CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 Parameter NUM_LANES, default 4: number of SIMD lanes issuing memory requests.
REQ-002 Parameter OPCODE_W, default 4: opcode width; SHALL be >= 3.
REQ-003 Parameter TIMEOUT, default 255: maximum cycles allowed in MEM_WAIT.
REQ-004 Parameter CNT_W, default 16: width of the retired-instruction counter.
REQ-005 Ports, one per line (name, direction, width, meaning):
- clk, in, 1: single clock; all state updates on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- start, in, 1: level request to run a block.
- lane_mask, in, NUM_LANES: active lanes; sampled on IDLE->FETCH.
- instr_valid, in, 1: fetcher presents opcode.
- opcode, in, OPCODE_W: instruction opcode.
- instr_ready, out, 1: sequencer accepts opcode.
- mem_ack, in, NUM_LANES: per-lane memory completion pulse.
- alu_enable, out, 1: ALU execute strobe.
- alu_op, out, 3: ALU operation select.
- reg_write, out, 1: register-file write strobe.
- mem_read, out, 1: load request, held during MEM_WAIT.
- mem_write, out, 1: store request, held during MEM_WAIT.
- done, out, 1: block finished.
- error, out, 1: sticky memory-timeout flag.
- instr_count, out, CNT_W: retired instructions.

Function
REQ-006 Opcode map SHALL be: 0 ADD, 1 SUB, 2 AND, 3 LOAD, 4 STORE, 5 OR, 6 XOR, 7 RET; any other value is NOP.
REQ-007 alu_op SHALL be: ADD 000, SUB 001, AND 010, OR 011, XOR 100; otherwise 000.
REQ-008 States SHALL be IDLE, FETCH, DECODE, EXECUTE, MEM_WAIT, WRITEBACK, DONE.
REQ-009 IDLE: all strobes low. start=1 -> FETCH; lane_mask latched in the same edge.
REQ-010 FETCH: instr_ready=1. instr_valid=1 -> opcode latched, go to DECODE. Otherwise stay in FETCH.
REQ-011 DECODE (1 cycle) transitions:
- ALU op -> EXECUTE.
- LOAD/STORE -> MEM_WAIT.
- RET -> DONE.
- NOP -> FETCH.
REQ-012 EXECUTE: alu_enable=1 and alu_op valid for exactly 1 cycle, then WRITEBACK.
REQ-013 WRITEBACK: reg_write=1 for exactly 1 cycle, then FETCH.
REQ-014 MEM_WAIT holds mem_read (LOAD) or mem_write (STORE) high every cycle.
- Per-lane sticky acked register ORs in mem_ack.
- Complete when ((acked | mem_ack) & mask) == mask.
- On completion, LOAD -> WRITEBACK; STORE -> FETCH.
REQ-015 acked SHALL clear on MEM_WAIT entry. mem_ack on lanes outside the mask, or outside MEM_WAIT, SHALL be ignored.
REQ-016 An all-zero mask SHALL complete MEM_WAIT after exactly 1 cycle.
REQ-017 Wait counter:
- Clears on MEM_WAIT entry and increments each MEM_WAIT cycle.
- Reaching TIMEOUT without completion -> error=1, go to DONE.
- Completion in the same cycle as TIMEOUT wins; no error.
REQ-018 instr_count SHALL increment by 1 on each instruction leaving DECODE, RET and NOP included. Wraps modulo 2^CNT_W. Clears on IDLE->FETCH.
REQ-019 DONE: done=1, all strobes low. start=0 -> IDLE. error holds until the next IDLE->FETCH.
REQ-020 Latency:
- ALU op: 4 cycles from FETCH handshake back to FETCH.
- STORE: 2+N cycles, N = MEM_WAIT cycles.
- LOAD: 3+N cycles.
REQ-021 At most one of alu_enable, mem_read, mem_write, reg_write SHALL be high in any cycle.

Reset
REQ-022 reset=1 SHALL immediately (asynchronously) force the following, regardless of current state, including mid-MEM_WAIT:
- IDLE state.
- All outputs 0.
- acked, wait counter, lane mask and instr_count cleared.
REQ-023 After reset deasserts, the first transition SHALL occur on a clk edge with start=1.

Verification
REQ-024 mask=4'b1111, opcodes ADD,SUB,RET -> alu_op 000 then 001, each with alu_enable then reg_write 1-cycle pulses; done=1; instr_count=3.
REQ-025 mask=4'b0101, LOAD; mem_ack=0001 at cycle 2, 0100 at cycle 5 -> mem_read high 5 cycles, reg_write 1 cycle later, stray mem_ack=1010 ignored.
REQ-026 TIMEOUT=8, STORE, no acks -> mem_write high 8 cycles, then error=1, done=1; completion on cycle 8 instead -> error=0.
REQ-027 mask=0, LOAD -> MEM_WAIT lasts 1 cycle; opcode 4'hF -> NOP, no strobes, instr_count increments.
REQ-028 reset asserted mid-MEM_WAIT -> mem_read drops without a clock edge; instr_count=0; restart runs cleanly.
REQ-029 CNT_W=2, five NOPs then RET -> instr_count wraps to 2.
